// File: rtl/traffic_countdown_if.sv
// Purpose: bundles the phase input and display/status outputs of traffic_countdown.
// Latency: n/a (signal bundle only).
// Backpressure: none; z is sampled every cycle and the outputs are free-running.
//
// Signals:
//   z         [2:0] one-hot light phase from the sequencer (001, 010, 100)
//   HEX0      [6:0] ones digit, active-low segments {g,f,e,d,c,b,a}
//   HEX1      [6:0] tens digit, same encoding
//   expired         one-cycle pulse when the count reaches 00
//   phase_err       high while z is not one-hot (registered)
interface traffic_countdown_if;
  logic [2:0] z;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic       expired;
  logic       phase_err;

  // Sequencer side: drives the phase, observes the display.
  modport master (
    output z,
    input  HEX0,
    input  HEX1,
    input  expired,
    input  phase_err
  );

  // Countdown side: consumes the phase, drives the display.
  modport slave (
    input  z,
    output HEX0,
    output HEX1,
    output expired,
    output phase_err
  );
endinterface

// File: rtl/traffic_countdown.sv
// Purpose: per-phase BCD countdown shown on two active-low 7-segment digits.
// Latency: 1 cycle from a z change to the reloaded count; decrement every TICK_DIV cycles.
// Backpressure: none; z is consumed every cycle, outputs always valid.
//
// Ports:
//   clk  system clock (rising edge)
//   rst  asynchronous active-low reset
//   bus  traffic_countdown_if.slave: z in; HEX0, HEX1, expired, phase_err out
module traffic_countdown #(
  parameter int TICK_DIV = 50_000_000,
  parameter int PH0_SEC  = 10,
  parameter int PH1_SEC  = 20,
  parameter int PH2_SEC  = 30
) (
  input logic                 clk,
  input logic                 rst,
  traffic_countdown_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [25:0] TICK_LAST = 26'(TICK_DIV - 1);
  localparam logic [6:0]  SEG_DASH  = 7'b0111111;

  // Phase durations pre-split into BCD digits at elaboration time.
  localparam logic [3:0] PH0_TENS = 4'(PH0_SEC / 10);
  localparam logic [3:0] PH0_ONES = 4'(PH0_SEC % 10);
  localparam logic [3:0] PH1_TENS = 4'(PH1_SEC / 10);
  localparam logic [3:0] PH1_ONES = 4'(PH1_SEC % 10);
  localparam logic [3:0] PH2_TENS = 4'(PH2_SEC / 10);
  localparam logic [3:0] PH2_ONES = 4'(PH2_SEC % 10);

  state_t      state_q, state_d;
  logic [2:0]  z_q, z_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [25:0] presc_q, presc_d;
  logic        expired_q, expired_d;
  logic        phase_err_q, phase_err_d;

  logic        z_legal;
  logic        show_count;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_DASH;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0011000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  assign z_legal = (bus.z == 3'b001) || (bus.z == 3'b010) || (bus.z == 3'b100);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      z_q         <= 3'b000;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      presc_q     <= 26'd0;
      expired_q   <= 1'b0;
      phase_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      z_q         <= z_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      presc_q     <= presc_d;
      expired_q   <= expired_d;
      phase_err_q <= phase_err_d;
    end
  end

  // Priority: illegal phase > phase change (load) > tick. A load therefore
  // swallows a coincident tick, including the final 01->00 step.
  always_comb begin
    state_d     = state_q;
    z_d         = z_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    presc_d     = presc_q;
    expired_d   = 1'b0;
    phase_err_d = !z_legal;

    if (!z_legal) begin
      state_d = FAULT;
      z_d     = 3'b000;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      presc_d = 26'd0;
    end else if (bus.z != z_q) begin
      // z_q is 000 after reset or a fault, so any legal z reloads here.
      state_d = RUN;
      z_d     = bus.z;
      presc_d = 26'd0;
      if (bus.z == 3'b001) begin
        tens_d = PH0_TENS;
        ones_d = PH0_ONES;
      end else if (bus.z == 3'b010) begin
        tens_d = PH1_TENS;
        ones_d = PH1_ONES;
      end else begin
        tens_d = PH2_TENS;
        ones_d = PH2_ONES;
      end
    end else if (state_q == RUN) begin
      if (presc_q == TICK_LAST) begin
        presc_d = 26'd0;
        if (ones_q != 4'd0) begin
          ones_d = ones_q - 4'd1;
        end else begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end
        if ((tens_q == 4'd0) && (ones_q == 4'd1)) begin
          expired_d = 1'b1;
          state_d   = DONE;
        end
      end else begin
        presc_d = presc_q + 26'd1;
      end
    end
    // DONE/IDLE/FAULT with unchanged z: hold everything, prescaler frozen.
  end

  // Digits show the count only once a phase has been loaded.
  assign show_count    = (state_q == RUN) || (state_q == DONE);
  assign bus.HEX0      = show_count ? seg7(ones_q) : SEG_DASH;
  assign bus.HEX1      = show_count ? seg7(tens_q) : SEG_DASH;
  assign bus.expired   = expired_q;
  assign bus.phase_err = phase_err_q;

endmodule

// File: tb/tb_traffic_countdown.sv
// Purpose: self-checking bench for traffic_countdown against a seconds-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_traffic_countdown;
  localparam int TICK_DIV = 4;
  localparam int PH0 = 10;
  localparam int PH1 = 20;
  localparam int PH2 = 30;

  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  traffic_countdown_if tc_if();

  traffic_countdown #(
    .TICK_DIV (TICK_DIV),
    .PH0_SEC  (PH0),
    .PH1_SEC  (PH1),
    .PH2_SEC  (PH2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (tc_if.slave)
  );

  // Model: remaining whole seconds plus cycles elapsed in the current second.
  logic [2:0] m_phase;
  int         m_rem;
  int         m_el;
  bit         m_show;
  bit         m_exp;
  bit         m_err;

  function automatic int secs(input logic [2:0] p);
    case (p)
      3'b001:  return PH0;
      3'b010:  return PH1;
      3'b100:  return PH2;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 3'b000; m_rem = 0; m_el = 0;
      m_show = 0; m_exp = 0; m_err = 0;
    end else begin
      m_exp = 0;
      if (!$onehot(tc_if.z)) begin
        m_err = 1; m_phase = 3'b000; m_rem = 0; m_el = 0; m_show = 0;
      end else begin
        m_err = 0;
        if (tc_if.z != m_phase) begin
          m_phase = tc_if.z; m_rem = secs(tc_if.z); m_el = 0; m_show = 1;
        end else if (m_rem > 0) begin
          m_el++;
          if (m_el == TICK_DIV) begin
            m_el = 0;
            m_rem--;
            if (m_rem == 0) m_exp = 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("hex0", 32'(tc_if.HEX0), 32'(m_show ? SEG[m_rem % 10] : DASH));
    chk("hex1", 32'(tc_if.HEX1), 32'(m_show ? SEG[m_rem / 10] : DASH));
    chk("expired", 32'(tc_if.expired), 32'(m_exp));
    chk("phase_err", 32'(tc_if.phase_err), 32'(m_err));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic lit(input string name, input logic [6:0] h1, input logic [6:0] h0);
    chk({name, "_hex1"}, 32'(tc_if.HEX1), 32'(h1));
    chk({name, "_hex0"}, 32'(tc_if.HEX0), 32'(h0));
  endtask

  logic [2:0] bad [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
  int n_exp;
  int exp_at;
  int r;

  initial begin
    rst = 1'b0;
    tc_if.z = 3'b001;
    #3;
    lit("reset", DASH, DASH);
    chk("reset_expired", 32'(tc_if.expired), 32'd0);
    chk("reset_err", 32'(tc_if.phase_err), 32'd0);
    #14 rst = 1'b1;

    // Load PH0 = 10, first decrement after 4 edges, expiry at edge 40.
    tick(1);
    lit("load10", SEG[1], SEG[0]);
    n_exp = 0; exp_at = -1;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (k == 4) lit("first_dec", 7'b1000000, 7'b0011000);
      if (tc_if.expired) begin n_exp++; exp_at = k; end
    end
    chk("exp_count", 32'(n_exp), 32'd1);
    chk("exp_edge", 32'(exp_at), 32'd40);
    lit("done00", 7'b1000000, 7'b1000000);
    tick(8);
    lit("done_hold", 7'b1000000, 7'b1000000);

    // PH2 = 30 across the tens borrow.
    tc_if.z = 3'b100;
    tick(1);
    lit("load30", 7'b0110000, 7'b1000000);
    for (int k = 1; k <= 120; k++) begin
      tick(1);
      if (k == 40) lit("show20", 7'b0100100, 7'b1000000);
      if (k == 44) lit("show19", 7'b1111001, 7'b0011000);
    end

    // Mid-count phase change at 06.
    tc_if.z = 3'b001;
    tick(1);
    tick(16);
    lit("show06", 7'b1000000, 7'b0000010);
    tc_if.z = 3'b010;
    tick(1);
    lit("reload20", 7'b0100100, 7'b1000000);
    chk("reload_noexp", 32'(tc_if.expired), 32'd0);

    // Phase change on the same edge as a tick.
    tick(3);
    tc_if.z = 3'b001;
    tick(1);
    lit("load_vs_tick", 7'b1111001, 7'b1000000);

    // Phase change on the same edge as the 01->00 step.
    tick(39);
    lit("show01", 7'b1000000, 7'b1111001);
    tc_if.z = 3'b100;
    tick(1);
    lit("load_vs_expire", 7'b0110000, 7'b1000000);
    chk("load_vs_expire_exp", 32'(tc_if.expired), 32'd0);

    // Illegal phase code during RUN.
    tick(5);
    tc_if.z = 3'b011;
    tick(1);
    chk("illegal_err", 32'(tc_if.phase_err), 32'd1);
    lit("illegal_dash", DASH, DASH);
    tc_if.z = 3'b100;
    tick(1);
    chk("recover_err", 32'(tc_if.phase_err), 32'd0);
    lit("recover30", 7'b0110000, 7'b1000000);

    // Asynchronous reset mid-count.
    tick(6);
    #1 rst = 1'b0;
    #1;
    lit("async_rst", DASH, DASH);
    chk("async_rst_exp", 32'(tc_if.expired), 32'd0);
    chk("async_rst_err", 32'(tc_if.phase_err), 32'd0);
    #10 rst = 1'b1;
    #2;
    lit("post_rst_dash", DASH, DASH);
    @(posedge clk);
    #2;
    lit("post_rst_load", 7'b0110000, 7'b1000000);

    // Random phase changes and illegal codes, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      tick(1);
      r = $urandom_range(0, 99);
      if (r < 1)      tc_if.z = bad[$urandom_range(0, 4)];
      else if (r < 3) tc_if.z = 3'b001 << $urandom_range(0, 2);
      else if (!$onehot(tc_if.z) && r < 30) tc_if.z = 3'b001 << $urandom_range(0, 2);
    end

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/traffic_countdown.md
# traffic_countdown

Per-phase countdown display stage that sits directly downstream of the traffic-light sequencer. It consumes the sequencer's one-hot light output, reloads a two-digit BCD down-counter with that phase's duration at every phase change, and decrements it once per second from an internal prescaler. It drives two active-low 7-segment digits and flags phase expiry and illegal phase codes.

## Interface
- TICK_DIV, 50_000_000, clk cycles per countdown tick (1 s at 50 MHz); legal range 2..2^26.
- PH0_SEC, 10, duration in seconds for phase 3'b001; legal range 1..99.
- PH1_SEC, 20, duration in seconds for phase 3'b010; legal range 1..99.
- PH2_SEC, 30, duration in seconds for phase 3'b100; legal range 1..99.

- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- z  input  3  one-hot light phase from the sequencer (001, 010, 100).
- HEX0  output  7  ones digit, active-low segments {g,f,e,d,c,b,a}.
- HEX1  output  7  tens digit, same encoding.
- expired  output  1  one-cycle pulse when the count reaches 00.
- phase_err  output  1  high while z is not one-hot.

## Operation
- Registers: z_q (3b), tens/ones (4b BCD each), prescaler (26b), state (2b), expired, phase_err.
- States: IDLE, RUN, DONE, FAULT.
- IDLE (reset state): digits show dash (7'b0111111). Any one-hot z -> load, RUN.
- Load: on each cycle where z is one-hot and z != z_q, set tens/ones = BCD(PHn_SEC) for the matching phase, clear prescaler, z_q <= z, state <= RUN. Load takes priority over tick and over DONE.
- RUN: prescaler counts 0..TICK_DIV-1; the tick fires on the cycle the prescaler equals TICK_DIV-1, and the prescaler returns to 0 on that cycle.
- Tick decrement:
  - If ones != 0, ones-1.
  - Else ones = 9 and tens-1.
  - Transition 01 -> 00 pulses expired and enters DONE.
- DONE: holds 00, no further pulses, prescaler frozen. Leaves only on a phase change (load) or an illegal z.
- Non-one-hot z (000, 011, 101, 110, 111), any state: state <= FAULT, phase_err=1, digits show dash, count and prescaler cleared, z_q <= 000.
- FAULT -> load on the next legal z; because z_q=000, any legal z counts as a change.
- Decoder: combinational from the registered BCD, digits 0-9 using the standard table (0=1000000, 1=1111001, ... 9=0011000). The tens digit shows its value including 0; there is no leading-zero blanking.
- Unchanged legal z in RUN: keep counting. The sequencer owns phase timing; this block never forces a phase change.

## Timing
- Reset asserted: immediately (asynchronous) HEX0=HEX1=7'b0111111, expired=0, phase_err=0, state IDLE, z_q=000, count 00, prescaler 0.
- Reset release: state takes effect from the first rising clk edge after deassertion.
- Reset mid-count: count is lost; the block reloads from the first legal z after release.
- Load latency: z changes before edge N -> new count visible on HEX after edge N (1 cycle).
- Tick period:
  - First decrement occurs TICK_DIV edges after the load edge.
  - Subsequent decrements every TICK_DIV edges.
  - A phase of PHn_SEC expires exactly PHn_SEC*TICK_DIV edges after the load edge.
- expired: high for exactly one cycle, coincident with the edge where HEX becomes 00.
- Simultaneous phase change and tick: the load wins; no decrement and no expired pulse.
- Simultaneous 01->00 tick and phase change: the load wins; expired is not asserted.
- phase_err: registered, asserted 1 cycle after illegal z appears, cleared 1 cycle after legal z.

## Test plan
- Reset then z=001, TICK_DIV=4, PH0_SEC=10 -> HEX1/HEX0 = 1/0 one cycle after z; shows 09 after 4 edges; 00 with a single expired pulse at edge 40.
- PH2_SEC=30 countdown across the tens borrow -> sequence 30, 29 ... 20, 19 ... 01, 00. The 20 -> 19 step shows ones=9 and tens=1 on the same cycle.
- z changes 001 -> 010 mid-count (at 06) -> reloads to 20 next cycle, prescaler restarts, no expired pulse.
- Phase change on the same cycle as a tick and as the 01->00 step -> load value shown, no decrement, expired stays 0.
- z=011 during RUN -> phase_err=1 and dashes one cycle later; z=100 -> loads 30, phase_err=0.
- rst pulled low asynchronously mid-count (between clock edges) -> outputs go to dash/0 immediately. After release, HEX holds dash until the next legal z, then loads it.
